// File: rtl/lstm_pkg.sv
// Shared types and elaboration helpers for the LSTM layer sequencer.
// Holds the FSM state enum, the K = max(N_INPUT, N_CELL) helper and the address-range check.
package lstm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } lstm_ctrl_state_t;

  function automatic int lstm_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Index width able to hold 0..n-1, never narrower than one bit.
  function automatic int lstm_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // True when every address region fits in the address space.
  function automatic bit lstm_addr_ok(
    input int aw,
    input int ni,
    input int nc,
    input int ts
  );
    longint lim;
    longint k;
    lim = longint'(1) << aw;
    k   = longint'(lstm_max(ni, nc));
    return (longint'(ts + 1) * nc <= lim) &&
           (longint'(ts) * ni <= lim) &&
           (longint'(nc) * k <= lim);
  endfunction

endpackage

// File: rtl/lstm_idx_cnt.sv
// Wrapping index counter with two base-address accumulators.
// Ports: clk, rst (async, active-high), clr_i (sync clear), en_i (advance),
//        idx_o (index), last_o (index at MAX-1), base_a_o/base_b_o (idx*STEP_A / idx*STEP_B).
module lstm_idx_cnt #(
  parameter int MAX    = 2,
  parameter int STEP_A = 0,
  parameter int STEP_B = 0,
  parameter int AW     = 12,
  parameter int IW     = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [IW-1:0] idx_o,
  output logic          last_o,
  output logic [AW-1:0] base_a_o,
  output logic [AW-1:0] base_b_o
);

  localparam logic [IW-1:0] LAST = IW'(MAX - 1);
  localparam logic [AW-1:0] SA   = AW'(STEP_A);
  localparam logic [AW-1:0] SB   = AW'(STEP_B);

  logic [IW-1:0] idx_q, idx_d;
  logic [AW-1:0] a_q, a_d;
  logic [AW-1:0] b_q, b_d;

  assign last_o   = (idx_q == LAST);
  assign idx_o    = idx_q;
  assign base_a_o = a_q;
  assign base_b_o = b_q;

  // Bases track idx*STEP by addition; a wrap returns all to zero.
  always_comb begin
    idx_d = idx_q;
    a_d   = a_q;
    b_d   = b_q;
    if (clr_i || (en_i && last_o)) begin
      idx_d = '0;
      a_d   = '0;
      b_d   = '0;
    end else if (en_i) begin
      idx_d = idx_q + IW'(1);
      a_d   = a_q + SA;
      b_d   = b_q + SB;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      idx_q <= idx_d;
      a_q   <= a_d;
      b_q   <= b_d;
    end
  end

endmodule

// File: rtl/lstm_layer_ctrl.sv
// Sequencer for one LSTM layer: walks t/cell/k, emits accumulate strobes,
// read addresses and h/c write strobes, with a start/busy/done handshake.
// Ports: clk, rst (async, active-high), start, busy, done, acc_x, acc_h,
//        addr_x, rd_addr_w/u/b/h/c, wr_h, wr_c, wr_addr_h, wr_addr_c.
// Build option: define LSTM_CTRL_STALL_EN to add a 'stall' input that freezes the sequencer.
module lstm_layer_ctrl
  import lstm_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int N_INPUT    = 53,
  parameter int N_CELL     = 53,
  parameter int TIMESTEP   = 7,
  parameter int PIPE_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
`ifdef LSTM_CTRL_STALL_EN
  input  logic                  stall,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  acc_x,
  output logic                  acc_h,
  output logic [ADDR_WIDTH-1:0] addr_x,
  output logic [ADDR_WIDTH-1:0] rd_addr_w,
  output logic [ADDR_WIDTH-1:0] rd_addr_u,
  output logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [ADDR_WIDTH-1:0] rd_addr_h,
  output logic [ADDR_WIDTH-1:0] rd_addr_c,
  output logic                  wr_h,
  output logic                  wr_c,
  output logic [ADDR_WIDTH-1:0] wr_addr_h,
  output logic [ADDR_WIDTH-1:0] wr_addr_c
);

  localparam int AW = ADDR_WIDTH;
  localparam int K  = lstm_max(N_INPUT, N_CELL);
  localparam int KW = lstm_w(K);
  localparam int CW = lstm_w(N_CELL);
  localparam int TW = lstm_w(TIMESTEP);
  localparam int DW = lstm_w(PIPE_LAT);

  localparam bit ADDR_OK = lstm_addr_ok(AW, N_INPUT, N_CELL, TIMESTEP);

  if (!ADDR_OK) begin : g_range_err
    $error("lstm_layer_ctrl: address regions exceed 2**ADDR_WIDTH");
  end

  localparam logic [KW:0]   NI_K   = (KW+1)'(N_INPUT);
  localparam logic [KW:0]   NC_K   = (KW+1)'(N_CELL);
  localparam logic [AW-1:0] NC_A   = AW'(N_CELL);
  localparam logic [DW-1:0] D_LAST = DW'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

  lstm_ctrl_state_t state_q, state_d;
  logic [DW-1:0]    d_q, d_d;

  logic stall_w;
  logic clr;
  logic k_en, cell_en, t_en;

`ifdef LSTM_CTRL_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  logic [KW-1:0] k_idx;
  logic          k_last;
  logic [AW-1:0] k_a;
  logic [AW-1:0] k_b_unused;

  logic [CW-1:0] cell_idx;
  logic          cell_last;
  logic [AW-1:0] cell_ni;
  logic [AW-1:0] cell_nc;

  logic [TW-1:0] t_idx_unused;
  logic          t_last;
  logic [AW-1:0] t_ni;
  logic [AW-1:0] t_nc;

  // k counter: base_a is simply k at address width.
  lstm_idx_cnt #(
    .MAX    (K),
    .STEP_A (1),
    .STEP_B (0),
    .AW     (AW),
    .IW     (KW)
  ) u_k (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (clr),
    .en_i     (k_en),
    .idx_o    (k_idx),
    .last_o   (k_last),
    .base_a_o (k_a),
    .base_b_o (k_b_unused)
  );

  lstm_idx_cnt #(
    .MAX    (N_CELL),
    .STEP_A (N_INPUT),
    .STEP_B (N_CELL),
    .AW     (AW),
    .IW     (CW)
  ) u_cell (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (clr),
    .en_i     (cell_en),
    .idx_o    (cell_idx),
    .last_o   (cell_last),
    .base_a_o (cell_ni),
    .base_b_o (cell_nc)
  );

  lstm_idx_cnt #(
    .MAX    (TIMESTEP),
    .STEP_A (N_INPUT),
    .STEP_B (N_CELL),
    .AW     (AW),
    .IW     (TW)
  ) u_t (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (clr),
    .en_i     (t_en),
    .idx_o    (t_idx_unused),
    .last_o   (t_last),
    .base_a_o (t_ni),
    .base_b_o (t_nc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
    end
  end

  // The final WRITE also wraps cell and t, so IDLE always sees zero indices.
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    clr     = 1'b0;
    k_en    = 1'b0;
    cell_en = 1'b0;
    t_en    = 1'b0;
    if (!stall_w) begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_ACC;
            clr     = 1'b1;
          end
        end
        ST_ACC: begin
          k_en = 1'b1;
          if (k_last) begin
            state_d = (PIPE_LAT == 0) ? ST_WRITE : ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (d_q == D_LAST) begin
            d_d     = '0;
            state_d = ST_WRITE;
          end else begin
            d_d = d_q + DW'(1);
          end
        end
        ST_WRITE: begin
          cell_en = 1'b1;
          state_d = ST_ACC;
          if (cell_last) begin
            t_en = 1'b1;
            if (t_last) begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  logic [AW-1:0] cell_a;
  assign cell_a = AW'(cell_idx);

  // Addresses are forced to zero in IDLE so the reset/idle view is all-zero.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE) && !stall_w;
    acc_x     = (state_q == ST_ACC) && !stall_w && ({1'b0, k_idx} < NI_K);
    acc_h     = (state_q == ST_ACC) && !stall_w && ({1'b0, k_idx} < NC_K);
    wr_h      = (state_q == ST_WRITE) && !stall_w;
    wr_c      = wr_h;
    addr_x    = '0;
    rd_addr_w = '0;
    rd_addr_u = '0;
    rd_addr_b = '0;
    rd_addr_h = '0;
    rd_addr_c = '0;
    wr_addr_h = '0;
    wr_addr_c = '0;
    if (busy) begin
      addr_x    = t_ni + k_a;
      rd_addr_w = cell_ni + k_a;
      rd_addr_u = cell_nc + k_a;
      rd_addr_h = t_nc + k_a;
      rd_addr_b = cell_a;
      rd_addr_c = t_nc + cell_a;
      wr_addr_h = t_nc + NC_A + cell_a;
      wr_addr_c = t_nc + NC_A + cell_a;
    end
  end

endmodule

// File: tb/tb_lstm_layer_ctrl.sv
// Self-checking bench for lstm_layer_ctrl (N_INPUT=3, N_CELL=2, TIMESTEP=2, PIPE_LAT=1).
// Expected cycle trace is built from nested t/cell/k loops with plain multiplication.
module tb_lstm_layer_ctrl;

  localparam int AW = 12;
  localparam int NI = 3;
  localparam int NC = 2;
  localparam int TS = 2;
  localparam int P  = 1;
  localparam int K  = (NI > NC) ? NI : NC;

`ifdef LSTM_CTRL_STALL_EN
  localparam bit HAS_STALL = 1'b1;
`else
  localparam bit HAS_STALL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stall;
  logic          busy, done, acc_x, acc_h, wr_h, wr_c;
  logic [AW-1:0] addr_x, rd_addr_w, rd_addr_u, rd_addr_b;
  logic [AW-1:0] rd_addr_h, rd_addr_c, wr_addr_h, wr_addr_c;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lstm_layer_ctrl #(
    .ADDR_WIDTH (AW),
    .N_INPUT    (NI),
    .N_CELL     (NC),
    .TIMESTEP   (TS),
    .PIPE_LAT   (P)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef LSTM_CTRL_STALL_EN
    .stall     (stall),
`endif
    .busy      (busy),
    .done      (done),
    .acc_x     (acc_x),
    .acc_h     (acc_h),
    .addr_x    (addr_x),
    .rd_addr_w (rd_addr_w),
    .rd_addr_u (rd_addr_u),
    .rd_addr_b (rd_addr_b),
    .rd_addr_h (rd_addr_h),
    .rd_addr_c (rd_addr_c),
    .wr_h      (wr_h),
    .wr_c      (wr_c),
    .wr_addr_h (wr_addr_h),
    .wr_addr_c (wr_addr_c)
  );

  // kind: 0 accumulate, 1 drain, 2 write, 3 done
  typedef struct {
    int kind;
    int t;
    int c;
    int k;
  } step_t;

  step_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic void build_trace();
    step_t s;
    exp_q.delete();
    for (int t = 0; t < TS; t++) begin
      for (int c = 0; c < NC; c++) begin
        for (int k = 0; k < K; k++) begin
          s = '{0, t, c, k};
          exp_q.push_back(s);
        end
        for (int p = 0; p < P; p++) begin
          s = '{1, t, c, 0};
          exp_q.push_back(s);
        end
        s = '{2, t, c, 0};
        exp_q.push_back(s);
      end
    end
    s = '{3, 0, 0, 0};
    exp_q.push_back(s);
  endfunction

  task automatic check_step(input step_t s, input bit st);
    chk("busy", busy, 1);
    chk("done", done, (s.kind == 3) && !st);
    chk("acc_x", acc_x, (s.kind == 0) && !st && (s.k < NI));
    chk("acc_h", acc_h, (s.kind == 0) && !st && (s.k < NC));
    chk("wr_h", wr_h, (s.kind == 2) && !st);
    chk("wr_c", wr_c, (s.kind == 2) && !st);
    if (s.kind == 0) begin
      if (s.k < NI) begin
        chk("addr_x", addr_x, s.t * NI + s.k);
        chk("rd_addr_w", rd_addr_w, s.c * NI + s.k);
      end
      if (s.k < NC) begin
        chk("rd_addr_u", rd_addr_u, s.c * NC + s.k);
        chk("rd_addr_h", rd_addr_h, s.t * NC + s.k);
      end
    end
    if (s.kind == 0 || s.kind == 2) begin
      chk("rd_addr_b", rd_addr_b, s.c);
      chk("rd_addr_c", rd_addr_c, s.t * NC + s.c);
    end
    if (s.kind == 2) begin
      chk("wr_addr_h", wr_addr_h, (s.t + 1) * NC + s.c);
      chk("wr_addr_c", wr_addr_c, (s.t + 1) * NC + s.c);
    end
  endtask

  task automatic idle_zero(input string tag);
    chk({tag, "_strobes"}, {busy, done, acc_x, acc_h, wr_h, wr_c}, 0);
    chk({tag, "_addr_x"}, addr_x, 0);
    chk({tag, "_rd_w"}, rd_addr_w, 0);
    chk({tag, "_rd_u"}, rd_addr_u, 0);
    chk({tag, "_rd_b"}, rd_addr_b, 0);
    chk({tag, "_rd_h"}, rd_addr_h, 0);
    chk({tag, "_rd_c"}, rd_addr_c, 0);
    chk({tag, "_wr_h"}, wr_addr_h, 0);
    chk({tag, "_wr_c"}, wr_addr_c, 0);
  endtask

  // Caller sets start=1 (stall=0) before the call; the first posedge accepts.
  // smode: 0 none, 1 random stalls, 2 three stalls on the k=1 cycle.
  // abort_at: trace index at which rst is asserted (-1 for none).
  task automatic run_one(input bit hold, input int smode, input int abort_at);
    bit st;
    int n;
    build_trace();
    for (int i = 0; i < exp_q.size(); i++) begin
      n = 0;
      do begin
        @(posedge clk);
        #1;
        start = hold ? 1'b1 : 1'($urandom & 1);
        st = 1'b0;
        if (HAS_STALL && smode == 1) st = ($urandom_range(0, 3) == 0) && (n < 4);
        if (HAS_STALL && smode == 2) st = (i == 1) && (n < 3);
        stall = st;
        @(negedge clk);
        check_step(exp_q[i], st);
        n++;
      end while (st);
      if (i == abort_at) begin
        #1 rst = 1'b1;
        #1 idle_zero("abort");
        repeat (2) begin
          @(negedge clk);
          chk("abort_no_done", done, 0);
          chk("abort_busy", busy, 0);
        end
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    start = hold;
    stall = 1'b0;
    @(negedge clk);
    chk("post_idle_busy", busy, 0);
    chk("post_idle_done", done, 0);
  endtask

  initial begin
    int gap;
    int cl;
    rst   = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    idle_zero("idle");

    start = 1'b1;
    run_one(1'b0, 0, -1);

    start = 1'b1;
    run_one(1'b1, 0, -1);
    run_one(1'b0, 0, -1);

    cl = $urandom_range(0, TS * NC - 1);
    start = 1'b1;
    run_one(1'b0, 0, cl * (K + P + 1) + K);
    @(negedge clk);
    idle_zero("after_abort");
    start = 1'b1;
    run_one(1'b0, 0, -1);

    repeat (4) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("gap_busy", busy, 0);
      end
      start = 1'b1;
      run_one(1'b0, 1, -1);
    end

    if (HAS_STALL) begin
      start = 1'b1;
      run_one(1'b0, 2, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/lstm_layer_ctrl.md
# lstm_layer_ctrl

Hardware sequencer for one LSTM layer of the datapath. It generates the accumulate strobes, memory read addresses and h/c write strobes that step the layer through every cell of every timestep. It is parametrised in input count, cell count, timestep count and pipeline drain, and controlled by a start/busy/done handshake. It sits between the top-level network controller and one layer port group of `datapath`.

## Interface
- `ADDR_WIDTH`, 12, width of every address output
- `N_INPUT`, 53, inputs per timestep (x vector length)
- `N_CELL`, 53, cells in the layer (h/c vector length)
- `TIMESTEP`, 7, timesteps per run
- `PIPE_LAT`, 1, idle cycles between the last accumulate and the h/c write (≥0)

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous reset, active-high
- `start`  in  1  run request, sampled in IDLE only
- `busy`  out  1  high from the start-accept edge until the done cycle
- `done`  out  1  one-cycle pulse after the final write
- `acc_x`  out  1  accumulate W·x term
- `acc_h`  out  1  accumulate U·h term
- `addr_x`  out  ADDR_WIDTH  x read address
- `rd_addr_w`, `rd_addr_u`, `rd_addr_b`  out  ADDR_WIDTH  weight/recurrent/bias read addresses
- `rd_addr_h`, `rd_addr_c`  out  ADDR_WIDTH  previous h / previous c read addresses
- `wr_h`, `wr_c`  out  1  h / c write strobes
- `wr_addr_h`, `wr_addr_c`  out  ADDR_WIDTH  h / c write addresses (always equal)

## Operation
- States: IDLE, ACC, DRAIN, WRITE, DONE.
- Indices: `t` (0..TIMESTEP-1), `cell` (0..N_CELL-1), `k` (0..K-1), where K = max(N_INPUT, N_CELL).
- IDLE: `start`=1 → ACC with t=cell=k=0. `start` is ignored in all other states.
- ACC: `acc_x` = (k < N_INPUT); `acc_h` = (k < N_CELL). At k=K-1 → DRAIN, or WRITE when PIPE_LAT=0.
- DRAIN: PIPE_LAT cycles with all strobes low, then WRITE.
- WRITE: one cycle with `wr_h`=`wr_c`=1. Next state:
  - cell < N_CELL-1 → cell+1, ACC
  - else t < TIMESTEP-1 → cell=0, t+1, ACC
  - else DONE
- DONE: `done`=1 for one cycle, then IDLE.
- Addresses:
  - `addr_x` = t·N_INPUT + k
  - `rd_addr_w` = cell·N_INPUT + k
  - `rd_addr_u` = cell·N_CELL + k
  - `rd_addr_h` = t·N_CELL + k
  - `rd_addr_b` = cell
  - `rd_addr_c` = t·N_CELL + cell
  - `wr_addr_h` = `wr_addr_c` = (t+1)·N_CELL + cell (region 0 holds initial h/c)
- Base addresses are held in registers and updated by addition at each index wrap. No multipliers.
- Address terms with k ≥ the relevant length are don't-care but must stay stable.
- Width: results are taken modulo 2^ADDR_WIDTH. An elaboration assertion fails if (TIMESTEP+1)·N_CELL, TIMESTEP·N_INPUT or N_CELL·K exceeds 2^ADDR_WIDTH.

## Timing
- Reset values: state IDLE, all indices 0, all outputs 0.
- Reset mid-run aborts immediately to IDLE. No `done` is produced.
- Outputs decode from registered state and counters only; there is no combinational path from `start`.
- The edge that samples `start`=1 enters ACC, so `acc_x`/`acc_h` are high in the following cycle with k=0.
- Each cell takes K + PIPE_LAT + 1 cycles. A run takes TIMESTEP·N_CELL·(K+PIPE_LAT+1) cycles, followed by one DONE cycle.
- `busy` is low in IDLE and high in all other states, including DONE.
- `start` held high during DONE has no effect. It is accepted on the first IDLE cycle after DONE.

## Configuration
- `LSTM_CTRL_STALL_EN` defined:
  - Adds input port `stall` (1 bit).
  - While `stall`=1: state and all counters hold; `acc_x`, `acc_h`, `wr_h`, `wr_c` and `done` are forced low; addresses hold.
  - A stall during DONE extends the DONE cycle; `done` pulses on the first unstalled DONE cycle.
- Not defined: the `stall` port is absent and the FSM never pauses.

## Structure
- Package `lstm_pkg`:
  - state enum `lstm_ctrl_state_t`
  - function `lstm_max(a,b)` for K
  - localparam address-range check helper
- Sub-module `lstm_idx_cnt`:
  - wrap counter with an enable and a base-address accumulator (base += STEP on wrap)
  - instantiated for k, cell and t

## Test plan
Configuration: N_INPUT=3, N_CELL=2, TIMESTEP=2, PIPE_LAT=1.
- Reset, then `start` pulse → `busy` high next cycle; 20 run cycles; `done` high on cycle 21 only; `busy` low on cycle 22.
- t=0, cell=1 → `rd_addr_w` 3,4,5; `rd_addr_u` 2,3 with `acc_h` low on k=2; `rd_addr_b`=1; WRITE has `wr_addr_h`=`wr_addr_c`=3.
- t=1, cell=0 → `addr_x` 3,4,5; `rd_addr_h` 2,3; `rd_addr_c`=2; `wr_addr_h`=4. Final write at address 5.
- `start` held high throughout the run → exactly one run; a second run begins the cycle after returning to IDLE.
- `rst` asserted mid-DRAIN → all outputs 0 immediately; no `done`; a fresh `start` restarts at t=cell=k=0.
- `LSTM_CTRL_STALL_EN` defined: `stall` for 3 cycles at k=1 → strobes low, addresses frozen; total run length increases by exactly 3.
